serial_exec_unit: RTL and testbench

Parametrised bit-serial execution unit and successor to the fixed 8-bit serial core. It adds a configurable datapath width, a small internal register file, eight ALU operations including subtract and compare, and carry/zero flags. Instructions arrive over a valid/ready handshake and execute LSB-first, one bit per cycle. Results are written back to the register file, and a done pulse marks completion.

---
 rtl/serial_core_pkg.sv | 34 +++
 rtl/serial_alu_bit.sv | 38 +++
 rtl/serial_exec_unit.sv | 135 +++++++++++++
 tb/tb_serial_exec_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_core_pkg.sv
// Shared definitions for the bit-serial execution unit: opcodes, FSM states
// and small decode/parameter-check helpers.
package serial_core_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_LI   = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    function automatic bit params_ok(input int width, input int nregs);
        return (width >= 2) && (nregs >= 2) && ((nregs & (nregs - 1)) == 0);
    endfunction

    // Ops whose carry chain is meaningful and is reported in carry_flag.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_CMP);
    endfunction

    function automatic logic is_subtract(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// One-bit slice of the serial ALU; the carry is held outside between cycles.
module serial_alu_bit
    import serial_core_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic [2:0] op,
    output logic       result,
    output logic       carry_out
);

    logic b_eff;
    logic sum;
    logic cout;

    // Subtraction is a + ~b + 1; the +1 comes from the carry preset in LOAD.
    assign b_eff = is_subtract(op) ? ~b : b;
    assign sum   = a ^ b_eff ^ carry_in;
    assign cout  = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);

    always_comb begin
        result    = 1'b0;
        carry_out = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_CMP: begin
                result    = sum;
                carry_out = cout;
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LI:   result = b;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_exec_unit.sv
// Bit-serial execution unit: register file, LSB-first operand shifters and a
// four-state sequencer that retires one instruction every WIDTH+3 cycles.
module serial_exec_unit
    import serial_core_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NREGS  = 4,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic [WIDTH-1:0]  instr_imm,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              carry_flag,
    output logic              zero_flag,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int CNT_W = $clog2(WIDTH);

    if (!params_ok(WIDTH, NREGS)) begin : g_bad_params
        $error("serial_exec_unit: WIDTH must be >= 2 and NREGS a power of two >= 2");
    end

    state_t              state;
    logic [2:0]          op_q;
    logic [REG_AW-1:0]   rd_q;
    logic [REG_AW-1:0]   rs1_q;
    logic [REG_AW-1:0]   rs2_q;
    logic [WIDTH-1:0]    imm_q;
    logic [WIDTH-1:0]    a_sr;
    logic [WIDTH-1:0]    b_sr;
    logic [WIDTH-1:0]    res_sr;
    logic                carry_q;
    logic                zacc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]    regs [NREGS];
    logic                alu_result;
    logic                alu_carry;

    serial_alu_bit u_alu (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .carry_in  (carry_q),
        .op        (op_q),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    // R0 is never written, but force the read to zero regardless.
    assign dbg_data    = (dbg_addr == '0) ? '0 : regs[dbg_addr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            result     <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            op_q       <= OP_ADD;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            carry_q    <= 1'b0;
            zacc_q     <= 1'b0;
            cnt_q      <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q  <= instr_op;
                        rd_q  <= instr_rd;
                        rs1_q <= instr_rs1;
                        rs2_q <= instr_rs2;
                        imm_q <= instr_imm;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Snapshot operands so rd may alias rs1/rs2.
                    a_sr    <= (op_q == OP_LI) ? '0 : regs[rs1_q];
                    b_sr    <= (op_q == OP_ADDI || op_q == OP_LI) ? imm_q : regs[rs2_q];
                    carry_q <= is_subtract(op_q);
                    cnt_q   <= '0;
                    zacc_q  <= 1'b0;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= {alu_result, res_sr[WIDTH-1:1]};
                    carry_q <= alu_carry;
                    zacc_q  <= zacc_q | alu_result;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        done  <= 1'b1;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    if (op_q != OP_CMP) begin
                        result <= res_sr;
                        if (rd_q != '0) begin
                            regs[rd_q] <= res_sr;
                        end
                    end
                    zero_flag  <= ~zacc_q;
                    carry_flag <= is_arith(op_q) ? carry_q : 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_exec_unit.sv
// Bench for serial_exec_unit: directed vector table, multi-cycle corner cases
// and random instructions checked against an arithmetic reference model.
module tb_serial_exec_unit;
    import serial_core_pkg::*;

    localparam int W  = 8;
    localparam int NR = 4;
    localparam int AW = 2;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    instr_op;
    logic [AW-1:0] instr_rd;
    logic [AW-1:0] instr_rs1;
    logic [AW-1:0] instr_rs2;
    logic [W-1:0]  instr_imm;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry_flag;
    logic          zero_flag;
    logic [AW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;

    int n_cmp  = 0;
    int n_fail = 0;

    int       mrf [NR];
    logic [7:0] m_res;
    logic     m_c;
    logic     m_z;

    typedef struct {
        logic [2:0] op;
        int         rd;
        int         rs1;
        int         rs2;
        logic [7:0] imm;
        logic [7:0] exp_res;
        logic       exp_c;
        logic       exp_z;
        int         dbg_a;
        logic [7:0] exp_dbg;
    } vec_t;

    vec_t vecs [10];

    serial_exec_unit #(.WIDTH(W), .NREGS(NR)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_imm   (instr_imm),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: instruction semantics in plain integer arithmetic.
    function automatic void model_step(input logic [2:0] op, input int rd, input int rs1,
                                       input int rs2, input int imm);
        int a, b, r;
        logic c;
        a = (op == OP_LI) ? 0 : mrf[rs1];
        b = (op == OP_ADDI || op == OP_LI) ? imm : mrf[rs2];
        c = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin r = a + b; c = (r > 255); end
            OP_SUB, OP_CMP:  begin r = a - b; c = (a >= b); end
            OP_AND:          r = a & b;
            OP_OR:           r = a | b;
            OP_XOR:          r = a ^ b;
            default:         r = b;
        endcase
        r = r & 255;
        m_c = c;
        m_z = (r == 0);
        if (op != OP_CMP) begin
            m_res = r[7:0];
            if (rd != 0) mrf[rd] = r;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) mrf[i] = 0;
        m_res = 8'h00;
        m_c   = 1'b0;
        m_z   = 1'b0;
    endfunction

    task automatic drive_fields(input logic [2:0] op, input int rd, input int rs1,
                                input int rs2, input logic [7:0] imm);
        instr_op  = op;
        instr_rd  = 2'(rd);
        instr_rs1 = 2'(rs1);
        instr_rs2 = 2'(rs2);
        instr_imm = imm;
    endtask

    // Issues one instruction; lat is the cycle index of done with the
    // handshake cycle as 0 (-1 on timeout). Returns one cycle after done.
    task automatic run_instr(input logic [2:0] op, input int rd, input int rs1,
                             input int rs2, input logic [7:0] imm,
                             output int lat, output int ready_hi);
        int guard;
        int cyc;
        lat = -1;
        ready_hi = 0;
        @(negedge clk);
        drive_fields(op, rd, rs1, rs2, imm);
        instr_valid = 1'b1;
        guard = 0;
        while (!instr_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        cyc = 1;
        while (cyc <= 50) begin
            if (instr_ready) ready_hi++;
            if (done) begin
                lat = cyc;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
        end
        model_step(op, rd, rs1, rs2, int'(imm));
    endtask

    task automatic check_dbg(input string name, input int addr, input logic [7:0] exp);
        dbg_addr = 2'(addr);
        #1;
        check(name, dbg_data, exp);
    endtask

    initial begin
        int lat, rhi, first_ready, dcount, cyc;
        logic [2:0] rop;
        int rrd, rs1, rs2;
        logic [7:0] rimm;
        logic saw_done;

        vecs[0] = '{OP_LI,   1, 0, 0, 8'h2D, 8'h2D, 1'b0, 1'b0, 1, 8'h2D};
        vecs[1] = '{OP_LI,   2, 0, 0, 8'h14, 8'h14, 1'b0, 1'b0, 2, 8'h14};
        vecs[2] = '{OP_ADD,  3, 1, 2, 8'h00, 8'h41, 1'b0, 1'b0, 3, 8'h41};
        vecs[3] = '{OP_LI,   1, 0, 0, 8'h01, 8'h01, 1'b0, 1'b0, 1, 8'h01};
        vecs[4] = '{OP_ADDI, 1, 1, 0, 8'hFF, 8'h00, 1'b1, 1'b1, 1, 8'h00};
        vecs[5] = '{OP_LI,   1, 0, 0, 8'h2D, 8'h2D, 1'b0, 1'b0, 1, 8'h2D};
        vecs[6] = '{OP_LI,   2, 0, 0, 8'h14, 8'h14, 1'b0, 1'b0, 2, 8'h14};
        vecs[7] = '{OP_SUB,  3, 2, 1, 8'h00, 8'hE7, 1'b0, 1'b0, 3, 8'hE7};
        vecs[8] = '{OP_CMP,  0, 1, 1, 8'h00, 8'hE7, 1'b1, 1'b1, 3, 8'hE7};
        vecs[9] = '{OP_LI,   0, 0, 0, 8'h55, 8'h55, 1'b0, 1'b0, 0, 8'h00};

        rstn        = 1'b0;
        instr_valid = 1'b0;
        drive_fields(3'd0, 0, 0, 0, 8'h00);
        dbg_addr    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        check("reset_ready", instr_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_carry", carry_flag, 0);
        check("reset_zero", zero_flag, 0);
        for (int a = 0; a < NR; a++) check_dbg("reset_dbg", a, 8'h00);

        for (int i = 0; i < 10; i++) begin
            run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, lat, rhi);
            check($sformatf("vec%0d_latency", i), lat, LAT);
            check($sformatf("vec%0d_ready_low", i), rhi, 0);
            check($sformatf("vec%0d_done_width", i), done, 0);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
            check($sformatf("vec%0d_carry", i), carry_flag, vecs[i].exp_c);
            check($sformatf("vec%0d_zero", i), zero_flag, vecs[i].exp_z);
            check_dbg($sformatf("vec%0d_dbg", i), vecs[i].dbg_a, vecs[i].exp_dbg);
        end
        check_dbg("cmp_leaves_r3", 3, 8'hE7);

        // instr_valid held high through a whole instruction: the second
        // accept happens only once the unit is back in IDLE.
        @(negedge clk);
        drive_fields(OP_LI, 2, 0, 0, 8'hAA);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        first_ready = -1;
        dcount = 0;
        cyc = 1;
        while (cyc <= 50) begin
            if (done) dcount++;
            if (instr_ready) begin
                first_ready = cyc;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("held_valid_ready_return", first_ready, W + 3);
        check("held_valid_single_done", dcount, 1);
        @(posedge clk);
        #1;
        check("held_valid_second_accept", busy, 1);
        instr_valid = 1'b0;
        model_step(OP_LI, 2, 0, 0, 8'hAA);
        model_step(OP_LI, 2, 0, 0, 8'hAA);
        saw_done = 1'b0;
        for (int k = 0; k < 50 && !saw_done; k++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("held_valid_second_done", saw_done, 1);
        @(posedge clk);
        #1;
        check("held_valid_result", result, 8'hAA);
        check_dbg("held_valid_dbg", 2, 8'hAA);

        for (int n = 0; n < 40; n++) begin
            rop  = 3'($urandom_range(0, 7));
            rrd  = $urandom_range(0, NR - 1);
            rs1  = $urandom_range(0, NR - 1);
            rs2  = $urandom_range(0, NR - 1);
            rimm = 8'($urandom);
            run_instr(rop, rrd, rs1, rs2, rimm, lat, rhi);
            check("rand_latency", lat, LAT);
            check("rand_result", result, m_res);
            check("rand_carry", carry_flag, m_c);
            check("rand_zero", zero_flag, m_z);
            for (int a = 0; a < NR; a++) check_dbg($sformatf("rand_dbg_r%0d", a), a, 8'(mrf[a]));
        end

        // Reset in the middle of EXEC: abort, no writeback, no done.
        run_instr(OP_LI, 1, 0, 0, 8'h5A, lat, rhi);
        run_instr(OP_LI, 2, 0, 0, 8'h33, lat, rhi);
        check_dbg("pre_abort_r1", 1, 8'h5A);
        @(negedge clk);
        drive_fields(OP_ADD, 3, 1, 2, 8'h00);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("abort_ready", instr_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_carry", carry_flag, 0);
        check("abort_zero", zero_flag, 0);
        for (int a = 0; a < NR; a++) check_dbg("abort_dbg", a, 8'h00);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        check_dbg("abort_r3_unwritten", 3, 8'h00);

        run_instr(OP_LI, 3, 0, 0, 8'h3C, lat, rhi);
        check("post_abort_latency", lat, LAT);
        check("post_abort_result", result, 8'h3C);
        check_dbg("post_abort_dbg", 3, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
